// File: rtl/div_share_pkg.sv
// Shared types and defaults for the time-multiplexed restoring divider controller.
package div_share_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_NREQ  = 4;
   localparam int DEF_WIDTH = 4;

   // Requester-id width; a single requester still needs one bit of id.
   function automatic int id_w(input int nreq);
      return (nreq <= 1) ? 1 : $clog2(nreq);
   endfunction

endpackage

// File: rtl/div_share_ctrl_rr_arbiter.sv
// Combinational round-robin search: first asserted request at or after ptr, wrapping.
module rr_arbiter
   import div_share_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int IDW  = id_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_idx,
   output logic            gnt_vld
);

   logic [IDW-1:0] idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      idx     = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = IDW'((int'(ptr) + k) % NREQ);
         if (en && !gnt_vld && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_idx  = idx;
            gnt_vld  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/div_share_ctrl.sv
// Round-robin controller sharing one restoring divider among NREQ requesters;
// one shift/subtract/restore step per cycle, tagged result over valid/ready.
module div_share_ctrl
   import div_share_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int WIDTH = DEF_WIDTH,
   parameter int IDW   = id_w(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_dividend,
   input  logic [NREQ*WIDTH-1:0] req_divisor,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_quot,
   output logic [WIDTH-1:0]      rsp_rem,
   output logic                  rsp_dbz,
   output logic                  busy
);

   localparam int CW = $clog2(WIDTH);

   state_t           state, nstate;
   logic [WIDTH:0]   a;
   logic [WIDTH-1:0] q, m;
   logic [IDW-1:0]   id, ptr;
   logic [CW-1:0]    cnt;
   logic             dbz;

   logic [NREQ-1:0]  gnt;
   logic [IDW-1:0]   g_idx;
   logic             g_vld;
   logic [WIDTH-1:0] dvd_g, dvs_g;
   logic [2*WIDTH:0] aq_sh;
   logic [WIDTH:0]   a_sh, t_diff;
   logic [WIDTH-1:0] q_sh;
   logic             last_step;

   // Arbitration only runs in IDLE; reset also masks req_ready so outputs read 0.
   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req     (req_valid),
      .ptr     (ptr),
      .en      ((state == IDLE) && !rst),
      .gnt     (gnt),
      .gnt_idx (g_idx),
      .gnt_vld (g_vld)
   );

   assign req_ready = gnt;
   assign dvd_g     = req_dividend[g_idx*WIDTH +: WIDTH];
   assign dvs_g     = req_divisor[g_idx*WIDTH +: WIDTH];

   // Restoring step: the sign of T at WIDTH+1 bits decides subtract vs restore.
   assign aq_sh     = {a, q} << 1;
   assign a_sh      = aq_sh[2*WIDTH:WIDTH];
   assign q_sh      = aq_sh[WIDTH-1:0];
   assign t_diff    = a_sh - {1'b0, m};
   assign last_step = (cnt == CW'(WIDTH - 1));

   assign rsp_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign rsp_id    = id;
   assign rsp_quot  = q;
   assign rsp_rem   = a[WIDTH-1:0];
   assign rsp_dbz   = dbz;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nstate;
   end

   always_comb begin
      nstate = state;
      case (state)
         IDLE: if (g_vld) nstate = (dvs_g == '0) ? DONE : ITER;
         ITER: if (last_step) nstate = DONE;
         DONE: if (rsp_ready) nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a   <= '0;
         q   <= '0;
         m   <= '0;
         id  <= '0;
         cnt <= '0;
         dbz <= 1'b0;
         ptr <= '0;
      end else begin
         case (state)
            IDLE: if (g_vld) begin
               id  <= g_idx;
               m   <= dvs_g;
               cnt <= '0;
               ptr <= (g_idx == IDW'(NREQ - 1)) ? '0 : g_idx + IDW'(1);
               // Zero divisor skips iteration and loads the defined result directly.
               if (dvs_g == '0) begin
                  dbz <= 1'b1;
                  q   <= '1;
                  a   <= {1'b0, dvd_g};
               end else begin
                  dbz <= 1'b0;
                  q   <= dvd_g;
                  a   <= '0;
               end
            end
            ITER: begin
               cnt <= cnt + CW'(1);
               if (t_diff[WIDTH]) begin
                  a <= a_sh;
                  q <= q_sh;
               end else begin
                  a <= t_diff;
                  q <= {q_sh[WIDTH-1:1], 1'b1};
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Bench for div_share_ctrl: directed scenarios plus a random run against a
// transaction-level model (integer division, round-robin rule, cycle latencies).
module tb_div_share_ctrl;

   localparam int NREQ = 4;
   localparam int W    = 4;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_dividend;
   logic [NREQ*W-1:0] req_divisor;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [W-1:0]      rsp_quot;
   logic [W-1:0]      rsp_rem;
   logic              rsp_dbz;
   logic              busy;

   int vecs = 0;
   int errs = 0;

   div_share_ctrl #(.NREQ(NREQ), .WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_dividend (req_dividend),
      .req_divisor  (req_divisor),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_id       (rsp_id),
      .rsp_quot     (rsp_quot),
      .rsp_rem      (rsp_rem),
      .rsp_dbz      (rsp_dbz),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input int dvd, input int dvs);
      req_valid[i] = v;
      req_dividend[i*W +: W] = W'(dvd);
      req_divisor[i*W +: W]  = W'(dvs);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Leaves time at the negedge of the first cycle with rsp_valid high (or timeout).
   task automatic wait_rsp(input string nm);
      int n;
      n = 0;
      @(negedge clk);
      while (rsp_valid !== 1'b1 && n < 40) begin
         tick();
         @(negedge clk);
         n++;
      end
      vecs++;
      if (rsp_valid !== 1'b1) begin
         errs++;
         $display("FAIL %s_timeout rsp_valid=%b after %0d cycles, want 1", nm, rsp_valid, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rsp_ready = 1'b1;
      req_valid = '1;
      req_dividend = '1;
      req_divisor = '1;
      tick();
      tick();
      @(negedge clk);
      vecs++;
      if (req_ready !== '0) begin errs++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
      vecs++;
      if ({rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dbz} !== '0) begin
         errs++;
         $display("FAIL reset_rsp got v=%b id=%0d q=%0d r=%0d dbz=%b want all 0",
                  rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dbz);
      end
      vecs++;
      if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
      req_valid = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_single();
      set_req(0, 1'b1, 13, 3);
      @(negedge clk);
      vecs++;
      if (req_ready !== 4'b0001) begin errs++; $display("FAIL single_ready got %b want 0001", req_ready); end
      tick();
      req_valid = '0;
      for (int k = 1; k <= W; k++) begin
         @(negedge clk);
         vecs++;
         if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
            errs++;
            $display("FAIL single_latency cycle t+%0d got v=%b busy=%b want v=0 busy=1", k, rsp_valid, busy);
         end
         tick();
      end
      @(negedge clk);
      vecs++;
      if ({rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dbz} !== {1'b1, 2'd0, 4'd4, 4'd1, 1'b0}) begin
         errs++;
         $display("FAIL single_rsp got v=%b id=%0d q=%0d r=%0d dbz=%b want v=1 id=0 q=4 r=1 dbz=0",
                  rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dbz);
      end
      tick();
      @(negedge clk);
      vecs++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         errs++;
         $display("FAIL single_after_hs got v=%b busy=%b want 0 0", rsp_valid, busy);
      end
      tick();
   endtask

   task automatic test_round_robin();
      int dvd[4] = '{8, 9, 15, 7};
      int dvs[4] = '{2, 4, 1, 15};
      int eq[4]  = '{4, 2, 15, 0};
      int er[4]  = '{0, 1, 0, 7};
      logic [3:0] want;
      int g;
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, dvd[i], dvs[i]);
      for (int j = 0; j < 5; j++) begin
         g = j % NREQ;
         want = 4'b0001 << g;
         @(negedge clk);
         vecs++;
         if (req_ready !== want) begin errs++; $display("FAIL rr_grant%0d got %b want %b", j, req_ready, want); end
         tick();
         wait_rsp("rr");
         vecs++;
         if ({rsp_id, rsp_quot, rsp_rem, rsp_dbz} !== {IDW'(g), W'(eq[g]), W'(er[g]), 1'b0}) begin
            errs++;
            $display("FAIL rr_rsp%0d got id=%0d q=%0d r=%0d dbz=%b want id=%0d q=%0d r=%0d dbz=0",
                     j, rsp_id, rsp_quot, rsp_rem, rsp_dbz, g, eq[g], er[g]);
         end
         tick();
      end
      req_valid = '0;
      tick();
   endtask

   task automatic test_dbz();
      set_req(2, 1'b1, 9, 0);
      @(negedge clk);
      vecs++;
      if (req_ready !== 4'b0100) begin errs++; $display("FAIL dbz_ready got %b want 0100", req_ready); end
      tick();
      req_valid = '0;
      @(negedge clk);
      vecs++;
      if ({rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dbz} !== {1'b1, 2'd2, 4'd15, 4'd9, 1'b1}) begin
         errs++;
         $display("FAIL dbz_rsp got v=%b id=%0d q=%0d r=%0d dbz=%b want v=1 id=2 q=15 r=9 dbz=1",
                  rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dbz);
      end
      tick();
   endtask

   task automatic test_backpressure();
      rsp_ready = 1'b0;
      set_req(1, 1'b1, 6, 4);
      @(negedge clk);
      vecs++;
      if (req_ready !== 4'b0010) begin errs++; $display("FAIL bp_ready got %b want 0010", req_ready); end
      tick();
      req_valid = '0;
      set_req(0, 1'b1, 11, 5);
      wait_rsp("bp");
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin tick(); @(negedge clk); end
         vecs++;
         if ({rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dbz, req_ready, busy} !==
             {1'b1, 2'd1, 4'd1, 4'd2, 1'b0, 4'b0000, 1'b1}) begin
            errs++;
            $display("FAIL bp_hold%0d got v=%b id=%0d q=%0d r=%0d dbz=%b rdy=%b busy=%b want v=1 id=1 q=1 r=2 dbz=0 rdy=0000 busy=1",
                     k, rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dbz, req_ready, busy);
         end
      end
      tick();
      rsp_ready = 1'b1;
      tick();
      @(negedge clk);
      vecs++;
      if (rsp_valid !== 1'b0 || req_ready !== 4'b0001) begin
         errs++;
         $display("FAIL bp_next_accept got v=%b rdy=%b want v=0 rdy=0001", rsp_valid, req_ready);
      end
      tick();
      req_valid = '0;
      wait_rsp("bp2");
      vecs++;
      if ({rsp_id, rsp_quot, rsp_rem} !== {2'd0, 4'd2, 4'd1}) begin
         errs++;
         $display("FAIL bp_rsp2 got id=%0d q=%0d r=%0d want id=0 q=2 r=1", rsp_id, rsp_quot, rsp_rem);
      end
      tick();
   endtask

   task automatic test_reset_mid_iter();
      set_req(3, 1'b1, 12, 5);
      @(negedge clk);
      vecs++;
      if (req_ready !== 4'b1000) begin errs++; $display("FAIL rmi_ready got %b want 1000", req_ready); end
      tick();
      req_valid = '0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      vecs++;
      if ({req_ready, rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dbz, busy} !== '0) begin
         errs++;
         $display("FAIL rmi_outputs got rdy=%b v=%b id=%0d q=%0d r=%0d dbz=%b busy=%b want all 0",
                  req_ready, rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dbz, busy);
      end
      for (int k = 0; k < W + 3; k++) begin
         tick();
         @(negedge clk);
         vecs++;
         if (rsp_valid !== 1'b0) begin errs++; $display("FAIL rmi_no_rsp cycle %0d got v=%b want 0", k, rsp_valid); end
      end
      tick();
      req_valid = '1;
      @(negedge clk);
      vecs++;
      if (req_ready !== 4'b0001) begin errs++; $display("FAIL rmi_ptr got %b want 0001", req_ready); end
      req_valid = '0;
      tick();
   endtask

   task automatic test_wrap();
      do_reset();
      set_req(3, 1'b1, 14, 3);
      @(negedge clk);
      vecs++;
      if (req_ready !== 4'b1000) begin errs++; $display("FAIL wrap_g3 got %b want 1000", req_ready); end
      tick();
      req_valid = '0;
      wait_rsp("wrap");
      vecs++;
      if ({rsp_id, rsp_quot, rsp_rem} !== {2'd3, 4'd4, 4'd2}) begin
         errs++;
         $display("FAIL wrap_rsp3 got id=%0d q=%0d r=%0d want id=3 q=4 r=2", rsp_id, rsp_quot, rsp_rem);
      end
      tick();
      set_req(1, 1'b1, 5, 2);
      set_req(3, 1'b1, 7, 7);
      @(negedge clk);
      vecs++;
      if (req_ready !== 4'b0010) begin errs++; $display("FAIL wrap_g1 got %b want 0010", req_ready); end
      tick();
      req_valid = '0;
      wait_rsp("wrap2");
      vecs++;
      if ({rsp_id, rsp_quot, rsp_rem} !== {2'd1, 4'd2, 4'd1}) begin
         errs++;
         $display("FAIL wrap_rsp1 got id=%0d q=%0d r=%0d want id=1 q=2 r=1", rsp_id, rsp_quot, rsp_rem);
      end
      tick();
   endtask

   task automatic test_random();
      int   m_ptr, m_wait, g, idx, dvd, dvs;
      bit   m_busy;
      logic [3:0]   e_rdy;
      logic [IDW-1:0] e_id;
      logic [W-1:0] e_q, e_r;
      logic         e_dbz;
      do_reset();
      m_ptr = 0; m_busy = 0; m_wait = 0;
      e_id = '0; e_q = '0; e_r = '0; e_dbz = 1'b0;
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < NREQ; i++)
            set_req(i, ($urandom_range(0, 99) < 35), $urandom_range(0, 15),
                    ($urandom_range(0, 6) == 0) ? 0 : $urandom_range(0, 15));
         rsp_ready = ($urandom_range(0, 99) < 70);
         @(negedge clk);
         if (!m_busy) begin
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
               idx = (m_ptr + k) % NREQ;
               if (req_valid[idx] && g < 0) g = idx;
            end
            e_rdy = (g < 0) ? 4'b0000 : (4'b0001 << g);
            vecs++;
            if ({req_ready, rsp_valid, busy} !== {e_rdy, 1'b0, 1'b0}) begin
               errs++;
               $display("FAIL rand_idle c=%0d got rdy=%b v=%b busy=%b want rdy=%b v=0 busy=0",
                        c, req_ready, rsp_valid, busy, e_rdy);
            end
            if (g >= 0) begin
               dvd   = int'(req_dividend[g*W +: W]);
               dvs   = int'(req_divisor[g*W +: W]);
               e_id  = IDW'(g);
               e_dbz = (dvs == 0);
               e_q   = e_dbz ? W'((1 << W) - 1) : W'(dvd / dvs);
               e_r   = e_dbz ? W'(dvd) : W'(dvd % dvs);
               m_wait = e_dbz ? 0 : W;
               m_busy = 1;
               m_ptr  = (g + 1) % NREQ;
            end
         end else if (m_wait > 0) begin
            vecs++;
            if ({req_ready, rsp_valid, busy} !== {4'b0000, 1'b0, 1'b1}) begin
               errs++;
               $display("FAIL rand_iter c=%0d got rdy=%b v=%b busy=%b want rdy=0000 v=0 busy=1",
                        c, req_ready, rsp_valid, busy);
            end
            m_wait--;
         end else begin
            vecs++;
            if ({req_ready, rsp_valid, busy, rsp_id, rsp_quot, rsp_rem, rsp_dbz} !==
                {4'b0000, 1'b1, 1'b1, e_id, e_q, e_r, e_dbz}) begin
               errs++;
               $display("FAIL rand_rsp c=%0d got rdy=%b v=%b id=%0d q=%0d r=%0d dbz=%b want rdy=0000 v=1 id=%0d q=%0d r=%0d dbz=%b",
                        c, req_ready, rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dbz, e_id, e_q, e_r, e_dbz);
            end
            if (rsp_ready) m_busy = 0;
         end
         tick();
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      tick();
   endtask

   initial begin
      rst = 1'b1;
      req_valid = '0;
      req_dividend = '0;
      req_divisor = '0;
      rsp_ready = 1'b1;
      test_reset();
      test_single();
      test_round_robin();
      test_dbz();
      test_backpressure();
      test_reset_mid_iter();
      test_wrap();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
